uart_alu_core: RTL and testbench
================================

UART_ALU_CORE -- requirements
Module: uart_alu_core

Interface
REQ-001 Parameter OPW, default 32: operand and result width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter NB, default OPW/8: bytes per operand; derived, not overridable.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 s_axis_tdata  input  8  request byte stream.
REQ-006 s_axis_tvalid  input  1  request byte valid.
REQ-007 s_axis_tready  output  1  core accepts request byte.
REQ-008 m_axis_tdata  output  8  response byte stream.
REQ-009 m_axis_tvalid  output  1  response byte valid.
REQ-010 m_axis_tready  input  1  downstream accepts response byte.
REQ-011 busy_o  output  1  high whenever state is not OPC.
REQ-012 err_o  output  1  one-cycle pulse on a protocol error.

Function
REQ-013 Packet format SHALL be: opcode, reserved byte (ignored), LEN[7:0], LEN[15:8], then payload; LEN is the total byte count including the 4 header bytes.
REQ-014 Operands SHALL be NB bytes each, little-endian; results SHALL be sent as NB bytes, little-endian.
REQ-015 Opcodes: 0xEC echo, 0x01 add, 0x02 mul, 0x03 signed div; any other value SHALL be treated as unknown.
REQ-016 States SHALL be OPC, RSVD, LENL, LENH, ECHO, OPND, EXEC, RESP, DROP.
REQ-017 Each header byte handshake SHALL advance OPC->RSVD->LENL->LENH.
REQ-018 On leaving LENH with a known opcode and valid LEN: echo SHALL go to ECHO, arithmetic SHALL go to OPND, and LEN=4 echo SHALL return to OPC.
REQ-019 LEN is invalid for arithmetic if (LEN-4) is not a multiple of NB or LEN<4+NB; for div it is invalid unless LEN=4+2*NB.
REQ-020 Unknown opcode or invalid LEN SHALL pulse err_o in the LENH-exit cycle, go to DROP, consume LEN-4 bytes with no response, then return to OPC (LEN<4 treated as 4).
REQ-021 ECHO SHALL forward LEN-4 payload bytes unchanged and in order through one output register.
REQ-022 In ECHO, s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready.
REQ-023 OPND SHALL assemble NB bytes into an operand register; the first operand SHALL load the accumulator.
REQ-024 For add, each later operand SHALL be added modulo 2^OPW in the cycle after its last byte, with no EXEC stall.
REQ-025 For mul, each later operand SHALL enter EXEC: an iterative shift-add taking exactly OPW cycles, product truncated to OPW bits; s_axis_tready SHALL be 0 during EXEC.
REQ-026 For div, after the second operand EXEC SHALL perform a restoring divide of OPW cycles on magnitudes, then apply sign; the quotient truncates toward zero.
REQ-027 Divide by zero SHALL return all-ones; most-negative / -1 SHALL return the most-negative value.
REQ-028 After the last operand (and EXEC, if any) the core SHALL enter RESP and emit NB result bytes LSB first.
REQ-029 In RESP, s_axis_tready SHALL be 0 and each byte SHALL hold until m_axis_tready.
REQ-030 After the final RESP handshake the core SHALL return to OPC, and s_axis_tready SHALL rise the following cycle.
REQ-031 m_axis_tdata SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-032 In OPC/RSVD/LENL/LENH/OPND/DROP, s_axis_tready SHALL be 1.
REQ-033 Payload byte counting SHALL use a 16-bit down-counter; LEN=0xFFFF SHALL be supported without wrap.

Reset
REQ-034 rst_ni low SHALL immediately force state OPC, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, err_o=0, and clear the accumulator and counters.
REQ-035 s_axis_tready SHALL go to 1 on the first clk_i edge after rst_ni deasserts.
REQ-036 Reset mid-packet SHALL discard the partial packet with no response; the next byte after release SHALL be parsed as an opcode.

Verification
REQ-037 Add: 01 00 0C 00 + 0x00000005, 0xFFFFFFFF -> response 04 00 00 00.
REQ-038 Mul: 3 operands 3, 5, 0x80000001 -> result 0x8000000F (truncated); EXEC stall = 32 cycles per operand after the first.
REQ-039 Div: -7 / 2 -> 0xFFFFFFFD; 5 / 0 -> 0xFFFFFFFF; 0x80000000 / -1 -> 0x80000000.
REQ-040 Echo with m_axis_tready toggling 1-of-3 cycles: 8 payload bytes -> same 8 bytes in order, none lost or duplicated.
REQ-041 Unknown opcode 0x7F with LEN=8, then a valid add -> err_o pulses once, no response for 0x7F, correct add result follows.
REQ-042 rst_ni pulsed after 6 bytes of an add packet, then a full add packet -> only the second result is emitted; repeat with OPW=16 (NB=2).

Source files
------------

// File: rtl/uart_alu_core.sv
// uart_alu_core: byte-stream request/response engine for echo, add, multiply
// and signed divide on OPW-bit little-endian operands.
//
// Ports:
//   clk_i          single clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   s_axis_tdata   request byte      s_axis_tvalid / s_axis_tready handshake
//   m_axis_tdata   response byte     m_axis_tvalid / m_axis_tready handshake
//   busy_o         high whenever the parser is not waiting for an opcode
//   err_o          one-cycle pulse when a header is rejected
//
// Packet: opcode, reserved, LEN[7:0], LEN[15:8], payload (LEN counts header).
module uart_alu_core #(
  parameter int unsigned OPW = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned NB    = OPW / 8;
  localparam logic [15:0] NB16  = 16'(NB);
  localparam logic [15:0] DIVPL = 16'(2 * NB);
  localparam logic [3:0]  NBM1  = 4'(NB - 1);

  typedef enum logic [3:0] {
    OPC, RSVD, LENL, LENH, ECHO, OPND, EXEC, RESP, DROP
  } state_t;

  typedef enum logic [2:0] {
    K_ECHO, K_ADD, K_MUL, K_DIV, K_BAD
  } kind_t;

  state_t           state_q;
  kind_t            kind_q;
  kind_t            opc_kind;
  logic             rdy_q;
  logic [7:0]       opc_q;
  logic [7:0]       len_lo_q;
  logic [15:0]      cnt_q;
  logic [3:0]       bidx_q;
  logic             first_q;
  logic [OPW-1:0]   opnd_q;
  logic [OPW-1:0]   acc_q;
  logic [OPW-1:0]   x_q;
  logic [OPW-1:0]   y_q;
  logic [OPW-1:0]   r_q;
  logic [6:0]       ecnt_q;
  logic             neg_q;
  logic             dz_q;
  logic [3:0]       rcnt_q;
  logic [7:0]       mdata_q;
  logic             mvalid_q;

  logic             s_hs;
  logic             out_free;
  logic [15:0]      len_full;
  logic [15:0]      pl;
  logic             hdr_bad;
  logic [OPW-1:0]   opnd_full;
  logic [OPW-1:0]   mul_prod;
  logic [OPW:0]     div_sh;
  logic [OPW:0]     div_tr;
  logic             div_bit;
  logic [OPW-1:0]   div_q;
  logic [OPW-1:0]   div_res;

  function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] v);
    return v[OPW-1] ? -v : v;
  endfunction

  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign out_free      = !mvalid_q || m_axis_tready;
  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvalid_q;
  assign busy_o        = (state_q != OPC);
  assign err_o         = (state_q == LENH) && s_hs && hdr_bad;

  // rdy_q is low only in reset and the first cycle after it, so every
  // accepting state is gated by it.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      OPC, RSVD, LENL, LENH, OPND, DROP: s_axis_tready = rdy_q;
      ECHO:                              s_axis_tready = rdy_q && out_free;
      default:                           s_axis_tready = 1'b0;
    endcase
  end

  // Header decode, evaluated while the LEN high byte is on the bus.
  always_comb begin
    len_full = {s_axis_tdata, len_lo_q};
    pl       = (len_full < 16'd4) ? 16'd0 : (len_full - 16'd4);
    case (opc_q)
      8'hEC:   opc_kind = K_ECHO;
      8'h01:   opc_kind = K_ADD;
      8'h02:   opc_kind = K_MUL;
      8'h03:   opc_kind = K_DIV;
      default: opc_kind = K_BAD;
    endcase
    case (opc_kind)
      K_ECHO:       hdr_bad = 1'b0;
      K_ADD, K_MUL: hdr_bad = (pl < NB16) || ((pl % NB16) != 16'd0);
      K_DIV:        hdr_bad = (pl != DIVPL);
      default:      hdr_bad = 1'b1;
    endcase
  end

  // Operand including the byte currently on the bus, so the last byte can be
  // consumed in the same cycle it is accepted.
  always_comb begin
    opnd_full = opnd_q;
    opnd_full[bidx_q*8 +: 8] = s_axis_tdata;
  end

  // One shift-add step (x = multiplicand, y = multiplier, r = partial product)
  // and one restoring-divide step (x = dividend shifting out, y = divisor,
  // r = partial remainder, quotient bits shift into x).
  always_comb begin
    mul_prod = r_q + (y_q[0] ? x_q : '0);
    div_sh   = {r_q, x_q[OPW-1]};
    div_tr   = div_sh - {1'b0, y_q};
    div_bit  = !div_tr[OPW];
    div_q    = {x_q[OPW-2:0], div_bit};
    if (dz_q)       div_res = '1;
    else if (neg_q) div_res = -div_q;
    else            div_res = div_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= OPC;
      kind_q   <= K_ECHO;
      rdy_q    <= 1'b0;
      opc_q    <= '0;
      len_lo_q <= '0;
      cnt_q    <= '0;
      bidx_q   <= '0;
      first_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      ecnt_q   <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      rcnt_q   <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      // Output register drains on its own; ECHO/RESP loads below override.
      if (m_axis_tready) mvalid_q <= 1'b0;
      if (state_q != RESP) rcnt_q <= 4'(NB);

      case (state_q)
        OPC: if (s_hs) begin
          opc_q   <= s_axis_tdata;
          state_q <= RSVD;
        end

        RSVD: if (s_hs) state_q <= LENL;

        LENL: if (s_hs) begin
          len_lo_q <= s_axis_tdata;
          state_q  <= LENH;
        end

        LENH: if (s_hs) begin
          kind_q  <= opc_kind;
          cnt_q   <= pl;
          first_q <= 1'b1;
          bidx_q  <= '0;
          if (hdr_bad)                  state_q <= (pl == 16'd0) ? OPC : DROP;
          else if (opc_kind == K_ECHO)  state_q <= (pl == 16'd0) ? OPC : ECHO;
          else                          state_q <= OPND;
        end

        ECHO: if (s_hs) begin
          mdata_q  <= s_axis_tdata;
          mvalid_q <= 1'b1;
          cnt_q    <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_q <= OPC;
        end

        DROP: if (s_hs) begin
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_q <= OPC;
        end

        OPND: if (s_hs) begin
          cnt_q  <= cnt_q - 16'd1;
          opnd_q <= opnd_full;
          if (bidx_q != NBM1) begin
            bidx_q <= bidx_q + 4'd1;
          end else begin
            bidx_q <= '0;
            if (first_q) begin
              first_q <= 1'b0;
              acc_q   <= opnd_full;
              if (cnt_q == 16'd1) state_q <= RESP;
            end else begin
              case (kind_q)
                K_ADD: begin
                  acc_q <= acc_q + opnd_full;
                  if (cnt_q == 16'd1) state_q <= RESP;
                end
                K_MUL: begin
                  r_q     <= '0;
                  x_q     <= acc_q;
                  y_q     <= opnd_full;
                  ecnt_q  <= 7'(OPW);
                  state_q <= EXEC;
                end
                default: begin
                  r_q     <= '0;
                  x_q     <= mag(acc_q);
                  y_q     <= mag(opnd_full);
                  neg_q   <= acc_q[OPW-1] ^ opnd_full[OPW-1];
                  dz_q    <= (opnd_full == '0);
                  ecnt_q  <= 7'(OPW);
                  state_q <= EXEC;
                end
              endcase
            end
          end
        end

        EXEC: begin
          ecnt_q <= ecnt_q - 7'd1;
          if (kind_q == K_MUL) begin
            r_q <= mul_prod;
            x_q <= x_q << 1;
            y_q <= y_q >> 1;
            if (ecnt_q == 7'd1) begin
              acc_q   <= mul_prod;
              state_q <= (cnt_q == 16'd0) ? RESP : OPND;
            end
          end else begin
            x_q <= div_q;
            r_q <= div_bit ? div_tr[OPW-1:0] : div_sh[OPW-1:0];
            if (ecnt_q == 7'd1) begin
              acc_q   <= div_res;
              state_q <= RESP;
            end
          end
        end

        // acc is shifted out LSB first; once all bytes are loaded the last
        // one is still valid, so the next m_axis_tready is the final handshake.
        RESP: begin
          if (rcnt_q != 4'd0) begin
            if (out_free) begin
              mdata_q  <= acc_q[7:0];
              mvalid_q <= 1'b1;
              acc_q    <= acc_q >> 8;
              rcnt_q   <= rcnt_q - 4'd1;
            end
          end else if (m_axis_tready) begin
            state_q <= OPC;
          end
        end

        default: state_q <= OPC;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_core.sv
// Directed bench for uart_alu_core: one OPW=32 instance and one OPW=16
// instance, each driven by its own request stream and response collector.
module tb_uart_alu_core;

  logic       clk;
  logic       rst_n [2];
  logic [7:0] sd    [2];
  logic       sv    [2];

  logic       sr0, sr1, mv0, mv1, busy0, busy1, err0, err1;
  logic [7:0] md0, md1;
  logic       mr0 = 1'b1;
  logic       mr1 = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int stall [2];
  int rmode0 = 0;
  int cyc0 = 0, errc0 = 0, stab0 = 0, errc1 = 0;
  logic       st0 = 1'b0;
  logic [7:0] hold0 = 8'h00;
  logic [7:0] rq0 [$];
  logic [7:0] rq1 [$];
  logic [7:0] pk  [$];

  uart_alu_core #(.OPW(32)) u0 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .s_axis_tdata(sd[0]), .s_axis_tvalid(sv[0]), .s_axis_tready(sr0),
    .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tready(mr0),
    .busy_o(busy0), .err_o(err0)
  );

  uart_alu_core #(.OPW(16)) u1 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .s_axis_tdata(sd[1]), .s_axis_tvalid(sv[1]), .s_axis_tready(sr1),
    .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(mr1),
    .busy_o(busy1), .err_o(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collectors: ready is chosen at the falling edge, then the values the next
  // rising edge will see are sampled.
  always @(negedge clk) begin
    cyc0++;
    mr0 = (rmode0 == 0) || (cyc0 % 3 == 0);
    #1;
    if (rst_n[0] === 1'b1 && st0 && (mv0 !== 1'b1 || md0 !== hold0)) stab0++;
    if (mv0 === 1'b1 && mr0) rq0.push_back(md0);
    st0   = (mv0 === 1'b1) && !mr0;
    hold0 = md0;
    if (err0 === 1'b1) errc0++;
  end

  always @(negedge clk) begin
    #1;
    if (mv1 === 1'b1 && mr1) rq1.push_back(md1);
    if (err1 === 1'b1) errc1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int u);
    return (u == 0) ? sr0 : sr1;
  endfunction

  function automatic int qsz(input int u);
    return (u == 0) ? rq0.size() : rq1.size();
  endfunction

  task automatic hdr(input logic [7:0] op, input logic [15:0] len);
    pk.delete();
    pk.push_back(op);
    pk.push_back(8'hA5);
    pk.push_back(len[7:0]);
    pk.push_back(len[15:8]);
  endtask

  task automatic opnd(input logic [63:0] v, input int nb);
    for (int i = 0; i < nb; i++) pk.push_back(v[8*i +: 8]);
  endtask

  task automatic send_byte(input int u, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    sd[u] = b;
    sv[u] = 1'b1;
    #1;
    while (rdy(u) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    stall[u] += n;
    if (n >= 1000) chk("tready_timeout", 64'(rdy(u)), 1);
    @(posedge clk);
  endtask

  task automatic send_n(input int u, input int cnt);
    stall[u] = 0;
    for (int i = 0; i < cnt; i++) send_byte(u, pk[i]);
    @(negedge clk);
    sv[u] = 1'b0;
  endtask

  task automatic send_pkt(input int u);
    send_n(u, pk.size());
  endtask

  task automatic wait_resp(input int u, input int n, input string tag);
    int k;
    k = 0;
    while (qsz(u) < n && k < 3000) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk({tag, "_n"}, 64'(qsz(u)), 64'(n));
  endtask

  task automatic get_res(input int u, input int nb, output logic [63:0] v);
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < nb; i++) begin
      b = 8'h00;
      if (u == 0) begin
        if (rq0.size() > 0) b = rq0.pop_front();
      end else begin
        if (rq1.size() > 0) b = rq1.pop_front();
      end
      v[8*i +: 8] = b;
    end
  endtask

  task automatic run_arith(input int u, input string tag, input int nb, input logic [63:0] exp);
    logic [63:0] v;
    send_pkt(u);
    wait_resp(u, nb, tag);
    get_res(u, nb, v);
    chk(tag, v, exp);
  endtask

  task automatic quiet(input int u, input string tag);
    repeat (6) @(negedge clk);
    #2;
    chk({tag, "_extra"}, 64'(qsz(u)), 0);
    chk({tag, "_busy"}, 64'((u == 0) ? busy0 : busy1), 0);
  endtask

  task automatic pulse_reset(input int u);
    @(negedge clk);
    rst_n[u] = 1'b0;
    #1;
    chk("rst_tready", 64'(rdy(u)), 0);
    chk("rst_busy", 64'((u == 0) ? busy0 : busy1), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n[u] = 1'b1;
  endtask

  logic [7:0] echo_pat [8];
  logic [63:0] v;
  int e0;

  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    sd[0] = 8'h00;   sd[1] = 8'h00;
    sv[0] = 1'b0;    sv[1] = 1'b0;
    stall[0] = 0;    stall[1] = 0;
    echo_pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Reset values while rst_ni is held low.
    #3;
    chk("rst_sready", 64'(sr0), 0);
    chk("rst_mvalid", 64'(mv0), 0);
    chk("rst_mdata", 64'(md0), 0);
    chk("rst_busy0", 64'(busy0), 0);
    chk("rst_err", 64'(err0), 0);
    chk("rst_sready16", 64'(sr1), 0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    chk("pre_edge_ready", 64'(sr0), 0);
    @(posedge clk);
    #1;
    chk("post_edge_ready", 64'(sr0), 1);
    chk("post_edge_ready16", 64'(sr1), 1);

    // Add with wraparound.
    hdr(8'h01, 16'h000C); opnd(64'h5, 4); opnd(64'hFFFFFFFF, 4);
    run_arith(0, "add_wrap", 4, 64'h00000004);
    chk("add_stall", 64'(stall[0]), 0);
    quiet(0, "add_wrap");

    // Three-operand multiply, truncated.
    hdr(8'h02, 16'h0010); opnd(64'd3, 4); opnd(64'd5, 4); opnd(64'h80000001, 4);
    run_arith(0, "mul3", 4, 64'h8000000F);
    chk("mul_stall", 64'(stall[0]), 32);
    quiet(0, "mul3");

    // Signed divides.
    hdr(8'h03, 16'h000C); opnd(64'hFFFFFFF9, 4); opnd(64'd2, 4);
    run_arith(0, "div_m7_2", 4, 64'hFFFFFFFD);
    hdr(8'h03, 16'h000C); opnd(64'd5, 4); opnd(64'd0, 4);
    run_arith(0, "div_by0", 4, 64'hFFFFFFFF);
    hdr(8'h03, 16'h000C); opnd(64'h80000000, 4); opnd(64'hFFFFFFFF, 4);
    run_arith(0, "div_ovf", 4, 64'h80000000);
    hdr(8'h03, 16'h000C); opnd(64'd100, 4); opnd(64'hFFFFFFF9, 4);
    run_arith(0, "div_100_m7", 4, 64'hFFFFFFF2);
    quiet(0, "div");

    // Echo under 1-of-3 backpressure.
    rmode0 = 1;
    hdr(8'hEC, 16'h000C);
    for (int i = 0; i < 8; i++) pk.push_back(echo_pat[i]);
    send_pkt(0);
    wait_resp(0, 8, "echo");
    for (int i = 0; i < 8; i++) begin
      get_res(0, 1, v);
      chk("echo_byte", v, 64'(echo_pat[i]));
    end
    quiet(0, "echo");
    rmode0 = 0;

    // Header-only echo returns straight to opcode state.
    hdr(8'hEC, 16'h0004);
    send_pkt(0);
    #1;
    chk("echo_len4_busy", 64'(busy0), 0);
    quiet(0, "echo_len4");

    // Unknown opcode is dropped, next add still works.
    e0 = errc0;
    hdr(8'h7F, 16'h0008); opnd(64'hEFBEADDE, 4);
    send_pkt(0);
    hdr(8'h01, 16'h000C); opnd(64'h10, 4); opnd(64'h20, 4);
    run_arith(0, "add_after_bad", 4, 64'h00000030);
    chk("err_pulses_unknown", 64'(errc0 - e0), 1);
    quiet(0, "unknown");

    // LEN not a multiple of operand size, and div with three operands.
    e0 = errc0;
    hdr(8'h01, 16'h000D); opnd(64'h0102030405060708, 8); pk.push_back(8'h09);
    send_pkt(0);
    hdr(8'h03, 16'h0010); opnd(64'd9, 4); opnd(64'd3, 4); opnd(64'd1, 4);
    send_pkt(0);
    chk("err_pulses_len", 64'(errc0 - e0), 2);
    quiet(0, "badlen");

    // Reset mid-packet, then a full packet.
    hdr(8'h01, 16'h000C); opnd(64'h5, 4); opnd(64'h6, 4);
    send_n(0, 6);
    pulse_reset(0);
    hdr(8'h01, 16'h000C); opnd(64'h7, 4); opnd(64'h8, 4);
    run_arith(0, "add_after_rst", 4, 64'h0000000F);
    quiet(0, "rst32");

    // OPW=16 instance.
    hdr(8'h01, 16'h0008); opnd(64'h1234, 2); opnd(64'h0001, 2);
    send_n(1, 6);
    pulse_reset(1);
    hdr(8'h01, 16'h0008); opnd(64'hFFFF, 2); opnd(64'h0002, 2);
    run_arith(1, "add16_after_rst", 2, 64'h0001);
    quiet(1, "rst16");
    hdr(8'h02, 16'h0008); opnd(64'h00FF, 2); opnd(64'h0101, 2);
    run_arith(1, "mul16", 2, 64'hFFFF);
    hdr(8'h03, 16'h0008); opnd(64'h8000, 2); opnd(64'hFFFF, 2);
    run_arith(1, "div16_ovf", 2, 64'h8000);
    quiet(1, "w16");
    chk("err16_none", 64'(errc1), 0);

    chk("hold_stable", 64'(stab0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
